// File: rtl/tff_timer_ctrl_pkg.sv
// Shared encodings for the tff-based interval timer: FSM states and T-vector actions.
package tff_timer_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        ACT_HOLD  = 3'd0,
        ACT_CLEAR = 3'd1,
        ACT_INC   = 3'd2,
        ACT_LOAD  = 3'd3,
        ACT_DEC   = 3'd4
    } act_e;

endpackage

// File: rtl/tff.sv
// Single T flip-flop cell: toggles on a rising clock edge when t_i is high.
module tff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic t_i,
    output logic q_o
);

    logic q_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= 1'b0;
        end else if (t_i) begin
            q_q <= ~q_q;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/tff_bank.sv
// WIDTH-bit bank of tff cells sharing clock and reset; T vector in, Q vector out.
module tff_bank #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] t_i,
    output logic [WIDTH-1:0] q_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff u_tff (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .t_i   (t_i[i]),
            .q_o   (q_o[i])
        );
    end

endmodule

// File: rtl/tff_timer_ctrl.sv
// Interval timer driving a tff bank purely through T inputs; one-shot or periodic done pulses.
// Define TFF_TIMER_DOWN_EN to add the down_i port and down-counting mode.
module tff_timer_ctrl
    import tff_timer_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             periodic_i,
    input  logic [WIDTH-1:0] limit_i,
`ifdef TFF_TIMER_DOWN_EN
    input  logic             down_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] count_o
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             periodic_q, periodic_d;
    logic             done_q, done_d;
    act_e             act;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] load_val;
    logic             down_sel;
    logic             start_down;

`ifdef TFF_TIMER_DOWN_EN
    logic down_q, down_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            down_q <= 1'b0;
        end else begin
            down_q <= down_d;
        end
    end

    always_comb begin
        down_d = down_q;
        if (state_q == ST_IDLE && start_i) begin
            down_d = down_i;
        end
    end

    assign down_sel   = down_q;
    assign start_down = down_i;
`else
    assign down_sel   = 1'b0;
    assign start_down = 1'b0;
`endif

    function automatic logic [WIDTH-1:0] inc_mask(input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] m;
        logic             carry;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            m[i]  = carry;
            carry = carry & q[i];
        end
        return m;
    endfunction

    function automatic logic [WIDTH-1:0] dec_mask(input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] m;
        logic             borrow;
        borrow = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            m[i]   = borrow;
            borrow = borrow & ~q[i];
        end
        return m;
    endfunction

    assign term_val = down_sel ? '0 : limit_q;
    // A start load uses the live input; a periodic reload uses the latched limit.
    assign load_val = (state_q == ST_IDLE) ? limit_i : limit_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            limit_q    <= '0;
            periodic_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            limit_q    <= limit_d;
            periodic_q <= periodic_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        limit_d    = limit_q;
        periodic_d = periodic_q;
        done_d     = 1'b0;
        act        = ACT_HOLD;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    limit_d    = limit_i;
                    periodic_d = periodic_i;
                    act        = start_down ? ACT_LOAD : ACT_CLEAR;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (count == term_val) begin
                    done_d = 1'b1;
                    if (periodic_q) begin
                        act = down_sel ? ACT_LOAD : ACT_CLEAR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    act = down_sel ? ACT_DEC : ACT_INC;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        t_vec = '0;
        unique case (act)
            ACT_HOLD:  t_vec = '0;
            ACT_CLEAR: t_vec = count;
            ACT_INC:   t_vec = inc_mask(count);
            ACT_LOAD:  t_vec = count ^ load_val;
            ACT_DEC:   t_vec = dec_mask(count);
            default:   t_vec = '0;
        endcase
    end

    tff_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .t_i   (t_vec),
        .q_o   (count)
    );

    assign count_o = count;
    assign busy_o  = (state_q == ST_RUN);
    assign done_o  = done_q;

endmodule

// File: tb/tb_tff_timer_ctrl.sv
// Self-checking bench for tff_timer_ctrl: vector table plus hand-written corner sequences.
module tb_tff_timer_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         stop;
    logic         periodic;
    logic [W-1:0] limit;
    logic         down;
    logic         busy;
    logic         done;
    logic [W-1:0] count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic         start;
        logic         stop;
        logic         per;
        logic [W-1:0] lim;
        logic [W-1:0] ecnt;
        logic         ebusy;
        logic         edone;
    } vec_t;

    typedef struct {
        logic [W-1:0] cnt;
        logic         busy;
        logic         done;
        string        name;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[39];

    always #5 clk = ~clk;

    tff_timer_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .stop_i     (stop),
        .periodic_i (periodic),
        .limit_i    (limit),
`ifdef TFF_TIMER_DOWN_EN
        .down_i     (down),
`endif
        .busy_o     (busy),
        .done_o     (done),
        .count_o    (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
    task automatic step(input logic st, input logic sp, input logic per, input logic dn,
                        input logic [W-1:0] lim, input logic [W-1:0] ecnt,
                        input logic eb, input logic ed, input string nm);
        exp_t e;
        @(negedge clk);
        start    = st;
        stop     = sp;
        periodic = per;
        down     = dn;
        limit    = lim;
        sb.push_back('{cnt: ecnt, busy: eb, done: ed, name: nm});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.name, ".count"}, 32'(count), 32'(e.cnt));
        chk({e.name, ".busy"}, 32'(busy), 32'(e.busy));
        chk({e.name, ".done"}, 32'(done), 32'(e.done));
    endtask

    initial begin
        int k;
        logic [W-1:0] last_cnt;

        tbl = '{
            // one-shot, limit 5
            '{1'b1, 1'b0, 1'b0, 8'd5, 8'd0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 8'd5, 8'd1, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 8'd5, 8'd2, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 8'd5, 8'd3, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 8'd5, 8'd4, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 8'd5, 8'd5, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 8'd5, 8'd5, 1'b0, 1'b1},
            '{1'b0, 1'b0, 1'b1, 8'd9, 8'd5, 1'b0, 1'b0},
            // periodic, limit 3, then stop
            '{1'b1, 1'b0, 1'b1, 8'd3, 8'd0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 8'd0, 8'd2, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 8'd0, 8'd3, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 8'd0, 8'd2, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 8'd0, 8'd3, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b1, 1'b0},
            '{1'b0, 1'b1, 1'b0, 8'd0, 8'd1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b0, 1'b0},
            // limit 0 one-shot
            '{1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1},
            '{1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0},
            // limit 0 periodic: done held high until stop
            '{1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1},
            '{1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1},
            '{1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0},
            // start and stop together in idle: start wins
            '{1'b1, 1'b1, 1'b0, 8'd2, 8'd0, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 8'd0, 8'd2, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 8'd0, 8'd2, 1'b0, 1'b1},
            '{1'b0, 1'b0, 1'b0, 8'd0, 8'd2, 1'b0, 1'b0},
            // start during run with another limit/mode is ignored
            '{1'b1, 1'b0, 1'b0, 8'd4, 8'd0, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b1, 8'd1, 8'd1, 1'b1, 1'b0},
            '{1'b1, 1'b0, 1'b1, 8'd1, 8'd2, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 8'd0, 8'd3, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 8'd0, 8'd4, 1'b1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 8'd0, 8'd4, 1'b0, 1'b1},
            '{1'b0, 1'b0, 1'b0, 8'd0, 8'd4, 1'b0, 1'b0}
        };

        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        periodic = 1'b0;
        limit    = '0;
        down     = 1'b0;
        #12;
        chk("reset.count", 32'(count), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 39; i++) begin
            step(tbl[i].start, tbl[i].stop, tbl[i].per, 1'b0, tbl[i].lim,
                 tbl[i].ecnt, tbl[i].ebusy, tbl[i].edone, $sformatf("vec[%0d]", i));
        end

        // Reset asserted mid-run, away from any clock edge.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 8'd0, 1'b1, 1'b0, "rst_run0");
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, W'(i), 1'b1, 1'b0, $sformatf("rst_run%0d", i));
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async.count", 32'(count), 32'd0);
        chk("rst_async.busy", 32'(busy), 32'd0);
        chk("rst_async.done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, $sformatf("rst_after%0d", i));
        end

        // Full-range periodic: done every 256 cycles, count wraps at the limit.
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'd255, 8'd0, 1'b1, 1'b0, "p255_k0");
        for (k = 1; k <= 600; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, W'(k % 256), 1'b1, (k % 256) == 0,
                 $sformatf("p255_k%0d", k));
        end
        last_cnt = W'(600 % 256);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, last_cnt, 1'b0, 1'b0, "p255_stop");
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, last_cnt, 1'b0, 1'b0, "p255_frozen");

`ifdef TFF_TIMER_DOWN_EN
        // Down periodic from 4: reload to 4 coincides with done.
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'd4, 8'd4, 1'b1, 1'b0, "down_k0");
        for (k = 1; k <= 12; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, W'(4 - (k % 5)), 1'b1, (k % 5) == 0,
                 $sformatf("down_k%0d", k));
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd2, 1'b0, 1'b0, "down_stop");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tff_timer_ctrl.md
Name: tff_timer_ctrl

Overview:
- Programmable interval timer controller.
- Sequences a WIDTH-bit bank of T flip-flops (the team's tff cell) as a synchronous counter.
- Every count, clear and hold action is expressed purely through the per-bit T inputs.
- Serves as the timing/sequencing block for downstream logic needing one-shot or periodic terminal-count pulses.

Parameters:
- WIDTH, 8, counter width in bits (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  level-sampled start request.
- stop  input  1  level-sampled abort request.
- periodic  input  1  mode select, latched on accepted start: 1 = auto-reload, 0 = one-shot.
- limit  input  WIDTH  terminal count, latched on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  registered one-cycle terminal-count pulse.
- count  output  WIDTH  current tff bank state (q of each bit).

Behaviour:
- Single clock domain: clk. Reset is asynchronous and active-high on port reset; it forces all state immediately, without waiting for a clock edge.
- Reset values: state=IDLE, count=0 (tff cells reset), busy=0, done=0, limit_r=0, periodic_r=0.
- T-input rules:
  - Hold: T=0.
  - Clear: T_i=q_i.
  - Increment: T_0=1; T_i = AND of q_0..q_{i-1}.
  - Count wraps 2^WIDTH-1 -> 0 naturally. Unreachable in normal operation, since limit_r bounds it.
- FSM states: IDLE, RUN.
- IDLE:
  - start=1: latch limit and periodic, apply Clear, go RUN.
  - Otherwise apply Hold. The count value left by a previous run is retained.
- RUN, in priority order:
  1. stop=1: Hold, go IDLE, no done pulse.
  2. count==limit_r with periodic_r=1: Clear, done=1 next cycle, stay RUN.
  3. count==limit_r with periodic_r=0: Hold, done=1 next cycle, go IDLE.
  4. Otherwise: Increment.
- start while in RUN is ignored. Inputs limit and periodic are ignored outside an accepted start.
- Timing, start accepted at edge e0 with limit L:
  - count=0 after e0; count=k after e0+k.
  - At edge e0+L+1, done rises for exactly one cycle.
  - Periodic mode: period L+1 cycles. count=0 and done=1 in the same cycle.
- limit=0: done one cycle after the start edge. Periodic mode then yields done continuously high, one pulse per cycle.
- busy = (state==RUN). It drops in the same cycle done rises for one-shot or stop.
- stop and start high together in IDLE: start is accepted. stop is only evaluated in RUN.
- Reset asserted mid-run: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: TFF_TIMER_DOWN_EN.
- Defined:
  - Adds input port down (1 bit), latched with limit on start.
  - down_r=1: start loads limit via T_i = q_i ^ limit_i.
  - Decrement rule: T_0=1; T_i = AND of ~q_0..~q_{i-1}.
  - Terminal condition is count==0.
  - On reload (periodic), reloads limit_r via the same XOR rule.
  - Timing and done/busy rules are identical to up mode.
- Undefined: no down port; up-count only, behaviour exactly as above.

Decomposition:
- Shared include tff_timer_defs.vh holds:
  - state encodings ST_IDLE=1'b0, ST_RUN=1'b1;
  - T-action select constants ACT_HOLD, ACT_CLEAR, ACT_INC, ACT_LOAD, ACT_DEC.
- One natural sub-module, tff_bank:
  - generate loop of WIDTH tff instances;
  - shared clk/reset;
  - T vector in, q vector out.
- tff_timer_ctrl contains the FSM, limit/mode registers and the T-vector computation.

Test Plan:
- Reset mid-count: WIDTH=8, start with limit=5, periodic=0, assert reset at count=3 -> count=0, busy=0, done=0 immediately; no done afterwards.
- One-shot: limit=5, periodic=0, start pulse at e0 -> count 0..5 over e0..e0+5; done=1 only in the cycle after e0+6; busy falls same edge; count holds 5.
- Periodic: limit=3, periodic=1 -> count 0,1,2,3,0,1,...; done every 4 cycles coincident with count=0; busy stays 1; stop then -> busy=0, count frozen, no done.
- Edge limits:
  - limit=0, periodic=0 -> done one cycle after start.
  - limit=255, periodic=1 -> done every 256 cycles, count never exceeds 255.
- Ignored start: start asserted while RUN with a different limit -> original limit_r still governs terminal count.
- With TFF_TIMER_DOWN_EN: down=1, limit=4, periodic=1 -> count 4,3,2,1,0,4,...; done coincident with each reload to 4.
